// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard/forwarding controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN,
        MEMWAIT,
        EXC
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    // Bit positions inside stall_o = {F,D,E,M,W} and flush_o = {D,E,M,W}
    localparam int ST_F = 4;
    localparam int ST_D = 3;
    localparam int ST_E = 2;
    localparam int ST_M = 1;
    localparam int ST_W = 0;
    localparam int FL_D = 3;
    localparam int FL_E = 2;
    localparam int FL_M = 1;
    localparam int FL_W = 0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Match and priority logic for a single source operand in ID and EX.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 7
) (
    input  logic [REG_AW-1:0] src_d,
    input  logic [REG_AW-1:0] src_e,
    input  logic [REG_AW-1:0] wreg_e,
    input  logic [REG_AW-1:0] wreg_m,
    input  logic [REG_AW-1:0] wreg_w,
    input  logic              regwrite_e,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic              memread_e,
    input  logic              memread_m,
    output logic [1:0]        fwd_d,
    output logic [1:0]        fwd_e,
    output logic              load_hit_e,
    output logic              load_hit_m
);

    logic d_hit_e;
    logic d_hit_m;
    logic e_hit_m;
    logic e_hit_w;

    // Register id 0 is hard-wired, so it never matches a producer.
    always_comb begin
        d_hit_e = regwrite_e && (wreg_e == src_d) && (src_d != '0);
        d_hit_m = regwrite_m && (wreg_m == src_d) && (src_d != '0);
        e_hit_m = regwrite_m && (wreg_m == src_e) && (src_e != '0);
        e_hit_w = regwrite_w && (wreg_w == src_e) && (src_e != '0);

        fwd_d = FWD_RF;
        if (d_hit_e && !memread_e) begin
            fwd_d = FWD_E;
        end else if (d_hit_m && !memread_m) begin
            fwd_d = FWD_M;
        end

        fwd_e = FWD_RF;
        if (e_hit_m && !memread_m) begin
            fwd_e = FWD_M;
        end else if (e_hit_w) begin
            fwd_e = FWD_W;
        end

        load_hit_e = d_hit_e && memread_e;
        load_hit_m = d_hit_m && memread_m;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and stall/flush sequencing for the 5-stage core.
// Outputs are decoded from the next state so they act in the current cycle.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW           = 7,
    parameter int N_SRC            = 2,
    parameter int EXC_FLUSH_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SRC*REG_AW-1:0] src_d,
    input  logic [N_SRC*REG_AW-1:0] src_e,
    input  logic                    branch_d,
    input  logic [REG_AW-1:0]       wreg_e,
    input  logic [REG_AW-1:0]       wreg_m,
    input  logic [REG_AW-1:0]       wreg_w,
    input  logic                    regwrite_e,
    input  logic                    regwrite_m,
    input  logic                    regwrite_w,
    input  logic                    memread_e,
    input  logic                    memread_m,
    input  logic                    md_busy,
    input  logic                    md_use_d,
    input  logic                    mem_stall,
    input  logic                    exc_req,
    output logic [4:0]              stall_o,
    output logic [3:0]              flush_o,
    output logic [2*N_SRC-1:0]      fwd_d,
    output logic [2*N_SRC-1:0]      fwd_e,
    output logic                    exc_taken_o
);

    localparam int CNT_W = (EXC_FLUSH_CYCLES > 1) ? $clog2(EXC_FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXC_FLUSH_CYCLES - 1);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic               pending;
    logic               pending_nx;
    logic               take_exc;
    logic               hazard;
    logic [N_SRC-1:0]   load_hit_e;
    logic [N_SRC-1:0]   load_hit_m;
    logic [2*N_SRC-1:0] fwd_d_raw;
    logic [2*N_SRC-1:0] fwd_e_raw;

    for (genvar i = 0; i < N_SRC; i++) begin : g_op
        hazard_fwd_sel #(
            .REG_AW(REG_AW)
        ) u_sel (
            .src_d      (src_d[i*REG_AW +: REG_AW]),
            .src_e      (src_e[i*REG_AW +: REG_AW]),
            .wreg_e     (wreg_e),
            .wreg_m     (wreg_m),
            .wreg_w     (wreg_w),
            .regwrite_e (regwrite_e),
            .regwrite_m (regwrite_m),
            .regwrite_w (regwrite_w),
            .memread_e  (memread_e),
            .memread_m  (memread_m),
            .fwd_d      (fwd_d_raw[2*i +: 2]),
            .fwd_e      (fwd_e_raw[2*i +: 2]),
            .load_hit_e (load_hit_e[i]),
            .load_hit_m (load_hit_m[i])
        );
    end

    assign hazard = (|load_hit_e) || (branch_d && (|load_hit_m)) || (md_busy && md_use_d);

    // An exception seen while memory is busy is parked in pending, never dropped.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pending_nx = pending;
        take_exc   = 1'b0;
        if (mem_stall && state != EXC) begin
            state_nx   = MEMWAIT;
            pending_nx = pending | exc_req;
        end else if ((exc_req || pending) && !mem_stall) begin
            state_nx   = EXC;
            cnt_nx     = CNT_LOAD;
            pending_nx = 1'b0;
            take_exc   = 1'b1;
        end else if (state == EXC) begin
            pending_nx = pending | exc_req;
            if (cnt == '0) begin
                state_nx = RUN;
            end else begin
                cnt_nx = cnt - CNT_W'(1);
            end
        end else begin
            state_nx = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pending <= pending_nx;
        end
    end

    always_comb begin
        stall_o     = '0;
        flush_o     = '0;
        exc_taken_o = 1'b0;
        fwd_d       = fwd_d_raw;
        fwd_e       = fwd_e_raw;
        if (rst) begin
            fwd_d = '0;
            fwd_e = '0;
        end else begin
            case (state_nx)
                MEMWAIT: begin
                    stall_o[ST_F] = 1'b1;
                    stall_o[ST_D] = 1'b1;
                    stall_o[ST_E] = 1'b1;
                    stall_o[ST_M] = 1'b1;
                    flush_o[FL_W] = 1'b1;
                end
                EXC: begin
                    flush_o[FL_D] = 1'b1;
                    flush_o[FL_E] = 1'b1;
                    flush_o[FL_M] = 1'b1;
                    flush_o[FL_W] = 1'b1;
                    exc_taken_o   = take_exc;
                end
                default: begin
                    if (hazard) begin
                        stall_o[ST_F] = 1'b1;
                        stall_o[ST_D] = 1'b1;
                        flush_o[FL_E] = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl with a per-cycle reference model.
module tb_pipeline_hazard_ctrl;

    localparam int AW  = 7;
    localparam int NS  = 2;
    localparam int EXN = 2;

    typedef struct {
        logic          rst;
        logic [AW-1:0] sd0, sd1, se0, se1;
        logic          br;
        logic [AW-1:0] we, wm, ww;
        logic          rwe, rwm, rww, mre, mrm, mdb, mdu, ms, exc;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [NS*AW-1:0]   src_d, src_e;
    logic               branch_d;
    logic [AW-1:0]      wreg_e, wreg_m, wreg_w;
    logic               regwrite_e, regwrite_m, regwrite_w;
    logic               memread_e, memread_m;
    logic               md_busy, md_use_d, mem_stall, exc_req;
    logic [4:0]         stall_o;
    logic [3:0]         flush_o;
    logic [2*NS-1:0]    fwd_d, fwd_e;
    logic               exc_taken_o;

    int n_checks = 0;
    int n_errors = 0;
    bit m_pending = 1'b0;
    int m_exc_left = 0;

    pipeline_hazard_ctrl #(
        .REG_AW(AW), .N_SRC(NS), .EXC_FLUSH_CYCLES(EXN)
    ) dut (
        .clk(clk), .rst(rst), .src_d(src_d), .src_e(src_e), .branch_d(branch_d),
        .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memread_e(memread_e), .memread_m(memread_m),
        .md_busy(md_busy), .md_use_d(md_use_d), .mem_stall(mem_stall), .exc_req(exc_req),
        .stall_o(stall_o), .flush_o(flush_o), .fwd_d(fwd_d), .fwd_e(fwd_e),
        .exc_taken_o(exc_taken_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t idle();
        vec_t v;
        v = '{default: 0};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst        = v.rst;
        src_d      = {v.sd1, v.sd0};
        src_e      = {v.se1, v.se0};
        branch_d   = v.br;
        wreg_e     = v.we;
        wreg_m     = v.wm;
        wreg_w     = v.ww;
        regwrite_e = v.rwe;
        regwrite_m = v.rwm;
        regwrite_w = v.rww;
        memread_e  = v.mre;
        memread_m  = v.mrm;
        md_busy    = v.mdb;
        md_use_d   = v.mdu;
        mem_stall  = v.ms;
        exc_req    = v.exc;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
    endtask

    task automatic compare(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", nm, $time, act, req);
        end
    endtask

    // Hand-computed expectation, sampled mid-cycle before the model's negedge check.
    task automatic expectLit(input string nm, input logic [4:0] s, input logic [3:0] f,
                             input logic [3:0] fd, input logic [3:0] fe, input logic t);
        #3;
        n_checks++;
        if ({stall_o, flush_o, fwd_d, fwd_e, exc_taken_o} !== {s, f, fd, fe, t}) begin
            n_errors++;
            $display("[TB] FAIL %s: got stall=%b flush=%b fwd_d=%b fwd_e=%b taken=%b expected stall=%b flush=%b fwd_d=%b fwd_e=%b taken=%b",
                     nm, stall_o, flush_o, fwd_d, fwd_e, exc_taken_o, s, f, fd, fe, t);
        end
    endtask

    function automatic logic [1:0] mdlFwdD(input logic [AW-1:0] s);
        if (s == 0) return 2'b00;
        if (regwrite_e && wreg_e == s && !memread_e) return 2'b01;
        if (regwrite_m && wreg_m == s && !memread_m) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [1:0] mdlFwdE(input logic [AW-1:0] s);
        if (s == 0) return 2'b00;
        if (regwrite_m && wreg_m == s && !memread_m) return 2'b10;
        if (regwrite_w && wreg_w == s) return 2'b01;
        return 2'b00;
    endfunction

    // Reference model: checks the outputs, then commits what the coming edge will do.
    task automatic checkOutput();
        logic [4:0] es;
        logic [3:0] ef, efd, efe;
        logic       et;
        bit         haz;
        es = '0; ef = '0; et = 1'b0; haz = 1'b0;
        for (int i = 0; i < NS; i++) begin
            logic [AW-1:0] sd, se;
            sd = src_d[i*AW +: AW];
            se = src_e[i*AW +: AW];
            efd[2*i +: 2] = mdlFwdD(sd);
            efe[2*i +: 2] = mdlFwdE(se);
            if (sd != 0 && memread_e && regwrite_e && wreg_e == sd) haz = 1'b1;
            if (sd != 0 && branch_d && memread_m && regwrite_m && wreg_m == sd) haz = 1'b1;
        end
        if (md_busy && md_use_d) haz = 1'b1;
        if (rst) begin
            efd = '0; efe = '0;
            m_pending = 1'b0; m_exc_left = 0;
        end else if (mem_stall && m_exc_left == 0) begin
            es = 5'b11110; ef = 4'b0001;
            if (exc_req) m_pending = 1'b1;
        end else if ((exc_req || m_pending) && !mem_stall) begin
            ef = 4'b1111; et = 1'b1;
            m_exc_left = EXN - 1;
            m_pending = 1'b0;
        end else if (m_exc_left > 0) begin
            ef = 4'b1111;
            m_exc_left--;
            if (exc_req) m_pending = 1'b1;
        end else if (haz) begin
            es = 5'b11000; ef = 4'b0100;
        end
        compare("stall_o", {3'b0, stall_o}, {3'b0, es});
        compare("flush_o", {4'b0, flush_o}, {4'b0, ef});
        compare("fwd_d", {4'b0, fwd_d}, {4'b0, efd});
        compare("fwd_e", {4'b0, fwd_e}, {4'b0, efe});
        compare("exc_taken_o", {7'b0, exc_taken_o}, {7'b0, et});
    endtask

    always @(negedge clk) checkOutput();

    initial begin
        vec_t v;
        v = idle(); v.rst = 1'b1;
        drive(v);
        applyStimulus(v);
        expectLit("reset", 5'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        applyStimulus(idle());
        expectLit("after_reset", 5'b0, 4'b0, 4'b0, 4'b0, 1'b0);

        v = idle(); v.rwe = 1; v.we = 3; v.sd0 = 3; v.sd1 = 4; v.br = 1;
        applyStimulus(v);
        expectLit("fwd_d_from_E", 5'b0, 4'b0, 4'b0001, 4'b0, 1'b0);
        v = idle(); v.rwm = 1; v.wm = 3; v.sd0 = 3; v.sd1 = 4; v.br = 1; v.se1 = 3;
        applyStimulus(v);
        expectLit("fwd_from_M", 5'b0, 4'b0, 4'b0010, 4'b1000, 1'b0);
        v = idle(); v.rwe = 1; v.we = 9; v.rwm = 1; v.wm = 9; v.rww = 1; v.ww = 9;
        v.sd1 = 9; v.se0 = 9;
        applyStimulus(v);
        expectLit("priority_E_over_M_M_over_W", 5'b0, 4'b0, 4'b0100, 4'b0010, 1'b0);

        v = idle(); v.rwe = 1; v.we = 5; v.mre = 1; v.sd0 = 5; v.sd1 = 6;
        applyStimulus(v);
        expectLit("load_use_stall", 5'b11000, 4'b0100, 4'b0, 4'b0, 1'b0);
        v = idle(); v.rwm = 1; v.wm = 5; v.mrm = 1; v.sd0 = 5; v.sd1 = 6;
        applyStimulus(v);
        expectLit("load_use_one_cycle", 5'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        v = idle(); v.rww = 1; v.ww = 5; v.se0 = 5;
        applyStimulus(v);
        expectLit("load_fwd_from_W", 5'b0, 4'b0, 4'b0, 4'b0001, 1'b0);

        v = idle(); v.rwe = 1; v.we = 5; v.mre = 1; v.sd0 = 5; v.br = 1;
        applyStimulus(v);
        expectLit("branch_load_1", 5'b11000, 4'b0100, 4'b0, 4'b0, 1'b0);
        v = idle(); v.rwm = 1; v.wm = 5; v.mrm = 1; v.sd0 = 5; v.br = 1;
        applyStimulus(v);
        expectLit("branch_load_2", 5'b11000, 4'b0100, 4'b0, 4'b0, 1'b0);
        v = idle(); v.rww = 1; v.ww = 5; v.sd0 = 5; v.br = 1;
        applyStimulus(v);
        expectLit("branch_load_done", 5'b0, 4'b0, 4'b0, 4'b0, 1'b0);

        v = idle(); v.ms = 1; v.exc = 1; v.rwe = 1; v.we = 5; v.mre = 1; v.sd0 = 5;
        applyStimulus(v);
        expectLit("memwait_1_hazard_suppressed", 5'b11110, 4'b0001, 4'b0, 4'b0, 1'b0);
        v = idle(); v.ms = 1;
        applyStimulus(v);
        expectLit("memwait_2", 5'b11110, 4'b0001, 4'b0, 4'b0, 1'b0);
        applyStimulus(v);
        expectLit("memwait_3", 5'b11110, 4'b0001, 4'b0, 4'b0, 1'b0);
        applyStimulus(idle());
        expectLit("pending_exc_taken", 5'b0, 4'b1111, 4'b0, 4'b0, 1'b1);
        applyStimulus(idle());
        expectLit("exc_flush_2", 5'b0, 4'b1111, 4'b0, 4'b0, 1'b0);
        applyStimulus(idle());
        expectLit("exc_done", 5'b0, 4'b0, 4'b0, 4'b0, 1'b0);

        v = idle(); v.mdb = 1; v.mdu = 1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(v);
            expectLit("md_stall", 5'b11000, 4'b0100, 4'b0, 4'b0, 1'b0);
        end
        v.mdb = 0;
        applyStimulus(v);
        expectLit("md_release", 5'b0, 4'b0, 4'b0, 4'b0, 1'b0);

        v = idle(); v.rwe = 1; v.rwm = 1; v.rww = 1; v.mre = 1; v.br = 1;
        applyStimulus(v);
        expectLit("reg_zero", 5'b0, 4'b0, 4'b0, 4'b0, 1'b0);

        v = idle(); v.ms = 1; v.exc = 1;
        applyStimulus(v);
        v = idle(); v.rst = 1;
        applyStimulus(v);
        expectLit("reset_in_memwait", 5'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        applyStimulus(idle());
        expectLit("pending_cleared", 5'b0, 4'b0, 4'b0, 4'b0, 1'b0);

        v = idle(); v.exc = 1;
        applyStimulus(v);
        expectLit("exc_immediate", 5'b0, 4'b1111, 4'b0, 4'b0, 1'b1);
        v = idle(); v.rst = 1; v.rwm = 1; v.wm = 2; v.se0 = 2;
        applyStimulus(v);
        expectLit("reset_in_exc", 5'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        applyStimulus(idle());
        expectLit("after_reset_in_exc", 5'b0, 4'b0, 4'b0, 4'b0, 1'b0);

        repeat (2) @(posedge clk);
        #7;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
